// File: rtl/mult_sequencer_if.sv
// Handshake and result bundle between the EX-stage control and the HI/LO
// multiply sequencer.
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hilo_read;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mult, mult_sign, operand_a, operand_b, hilo_read,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start_mult, mult_sign, operand_a, operand_b, hilo_read,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mult_sequencer.sv
// Shift-add multiplier for MULT/MULTU: one partial-product step per cycle,
// owns HI/LO and raises the pipeline stall while a product is in flight.
module mult_sequencer #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  mult_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               neg;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               busy_int;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] addend, product;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start_mult) next_state = CALC;
      CALC:    if (count == LAST_STEP) next_state = SIGN;
      SIGN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_int = 1'b0;
    case (state)
      CALC, SIGN: busy_int = 1'b1;
      default:    busy_int = 1'b0;
    endcase
  end

  // Signed operands are reduced to magnitudes; the sign is reapplied in SIGN.
  always_comb begin
    mag_a   = (bus.mult_sign && bus.operand_a[WIDTH-1]) ? (~bus.operand_a + WIDTH'(1)) : bus.operand_a;
    mag_b   = (bus.mult_sign && bus.operand_b[WIDTH-1]) ? (~bus.operand_b + WIDTH'(1)) : bus.operand_b;
    addend  = {{WIDTH{1'b0}}, mcand} << count;
    product = neg ? (~acc + (2*WIDTH)'(1)) : acc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_mult) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            acc    <= '0;
            count  <= '0;
            neg    <= bus.mult_sign & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + addend;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        SIGN: begin
          hi_q   <= product[2*WIDTH-1:WIDTH];
          lo_q   <= product[WIDTH-1:0];
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stall only while busy, so IDLE reads and the done cycle pass straight through.
  assign bus.busy  = busy_int;
  assign bus.stall = busy_int & (bus.hilo_read | bus.start_mult);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule
